// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory bus responder.
package cpu_bus_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [3:0] IO_OUT    = 4'd0;
  localparam logic [3:0] IO_CYCLES = 4'd1;
  localparam logic [3:0] IO_STATUS = 4'd2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cpu_bus_io_regs.sv
// I/O window registers: output port, free-running cycle counter, status, read mux.
// Write-protect sticky flag exists only when RESP_WRITE_PROTECT_EN is defined.
module cpu_bus_io_regs
  import cpu_bus_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        busy,
  input  logic        out_we,
  input  logic        wp_set,
  input  logic [3:0]  offset,
  input  logic [31:0] datai,
  output logic [31:0] rdata,
  output logic [31:0] io_out,
  output logic        io_valid,
  output logic        wp_err
);

  logic [31:0] cycle_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      io_out    <= '0;
      io_valid  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      io_valid <= out_we;
      if (out_we) io_out <= datai;
      if (run) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

`ifdef RESP_WRITE_PROTECT_EN
  always_ff @(posedge clock) begin
    if (!reset)      wp_err <= 1'b0;
    else if (wp_set) wp_err <= 1'b1;
  end
`else
  logic unused_wp;
  assign unused_wp = wp_set;
  assign wp_err    = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      IO_OUT:    rdata = io_out;
      IO_CYCLES: rdata = cycle_cnt;
      IO_STATUS: rdata = {30'b0, wp_err, busy};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU memory bus target: word RAM with post-reset zero sweep plus a 16-word I/O window.
// Optional macro RESP_WRITE_PROTECT_EN drops RUN writes below PROT_WORDS and flags wp_err.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int unsigned PROT_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datai,
  input  logic        rw,
  output logic [31:0] data,
  output logic [31:0] io_out,
  output logic        io_valid,
  output logic        busy,
  output logic        wp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_next;
  logic [31:0]       mem [DEPTH];

  logic        run;
  logic        ram_hit;
  logic        io_hit;
  logic [31:0] io_diff;
  logic        cpu_wr;
  logic        prot_hit;
  logic        ram_we;
  logic        out_we;
  logic        wp_set;
  logic [31:0] io_rdata;

  assign run  = (state == RUN);
  assign busy = ~run;

  assign ram_hit  = (address[31:ADDR_W] == '0);
  assign io_diff  = address - IO_BASE;
  assign io_hit   = (address >= IO_BASE) && (io_diff[31:4] == '0);
  assign cpu_wr   = run && (rw == RW_WRITE);
  assign prot_hit = (address < 32'(PROT_WORDS));
  assign wp_set   = cpu_wr && ram_hit && prot_hit;
  assign out_we   = cpu_wr && io_hit && (io_diff[3:0] == IO_OUT);

`ifdef RESP_WRITE_PROTECT_EN
  assign ram_we = cpu_wr && ram_hit && !prot_hit;
`else
  assign ram_we = cpu_wr && ram_hit;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_next;
    end
  end

  always_comb begin
    state_next = state;
    clr_next   = clr_ptr;
    if (state == CLEAR) begin
      clr_next = clr_ptr + 1'b1;
      if (clr_ptr == '1) state_next = RUN;
    end
  end

  // Sweep writes are harmless while reset is held, so the RAM port needs no reset term.
  always_ff @(posedge clock) begin
    if (!run)        mem[clr_ptr] <= '0;
    else if (ram_we) mem[address[ADDR_W-1:0]] <= datai;
  end

  always_comb begin
    data = '0;
    if (run) begin
      if (ram_hit)     data = mem[address[ADDR_W-1:0]];
      else if (io_hit) data = io_rdata;
    end
  end

  cpu_bus_io_regs u_io_regs (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .busy     (busy),
    .out_we   (out_we),
    .wp_set   (wp_set),
    .offset   (io_diff[3:0]),
    .datai    (datai),
    .rdata    (io_rdata),
    .io_out   (io_out),
    .io_valid (io_valid),
    .wp_err   (wp_err)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder against a behavioural bus model.
module tb_cpu_mem_responder;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;
  localparam int unsigned PROT_WORDS = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] datai;
  logic        rw;
  logic [31:0] data;
  logic [31:0] io_out;
  logic        io_valid;
  logic        busy;
  logic        wp_err;

  cpu_mem_responder #(
    .ADDR_W     (ADDR_W),
    .IO_BASE    (IO_BASE),
    .PROT_WORDS (PROT_WORDS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .datai    (datai),
    .rw       (rw),
    .data     (data),
    .io_out   (io_out),
    .io_valid (io_valid),
    .busy     (busy),
    .wp_err   (wp_err)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Behavioural model of the bus target
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  int unsigned m_clr;
  logic [31:0] m_cnt;
  logic [31:0] m_io_out;
  bit          m_io_valid;
  bit          m_wp;

  logic [31:0] obs_data;
  bit          obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return (a >= IO_BASE) && ((a - IO_BASE) < 32'd16);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!m_run) return '0;
    if (a < DEPTH) return m_mem[a];
    if (is_io(a)) begin
      case (a - IO_BASE)
        32'd0:   return m_io_out;
        32'd1:   return m_cnt;
        32'd2:   return {30'b0, m_wp, 1'b0};
        default: return '0;
      endcase
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_clr = 0; m_cnt = '0;
    m_io_out = '0; m_io_valid = 0; m_wp = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model_update(input logic [31:0] a, input logic r, input logic [31:0] d);
    bit nv;
    nv = 0;
    if (m_run) begin
      if (r == 1'b0) begin
        if (a < DEPTH) begin
`ifdef RESP_WRITE_PROTECT_EN
          if (a < PROT_WORDS) m_wp = 1;
          else m_mem[a] = d;
`else
          m_mem[a] = d;
`endif
        end else if (is_io(a) && (a == IO_BASE)) begin
          m_io_out = d;
          nv = 1;
        end
      end
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_clr++;
      if (m_clr == DEPTH) m_run = 1;
    end
    m_io_valid = nv;
  endtask

  // One bus cycle: drive, check combinational read and registered state, then clock the model.
  task automatic cycle(input logic [31:0] a, input logic r, input logic [31:0] d);
    @(negedge clock);
    address = a; rw = r; datai = d;
    #1;
    obs_data = data;
    obs_busy = busy;
    chk("data", data, model_read(a));
    chk("busy", {31'b0, busy}, {31'b0, ~m_run});
    chk("io_out", io_out, m_io_out);
    chk("io_valid", {31'b0, io_valid}, {31'b0, m_io_valid});
    chk("wp_err", {31'b0, wp_err}, {31'b0, m_wp});
    @(posedge clock);
    model_update(a, r, d);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clock);
    reset = 1'b0; rw = 1'b1; address = '0; datai = '0;
    repeat (n) @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_io_out", io_out, '0);
    chk("rst_io_valid", {31'b0, io_valid}, '0);
    chk("rst_wp_err", {31'b0, wp_err}, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(3))
      0, 1:    return 32'($urandom_range(DEPTH - 1));
      2:       return IO_BASE + 32'($urandom_range(15));
      default: return 32'(DEPTH) + 32'($urandom_range(1000000));
    endcase
  endfunction

  task automatic run_clear();
    int unsigned busy_cnt = 0;
    int unsigned guard = 0;
    while (!m_run && guard < DEPTH + 10) begin
      if (guard % 3 == 0) cycle(32'd5, 1'b1, '0);
      else cycle(rand_addr(), 1'($urandom_range(1)), $urandom);
      if (obs_busy) busy_cnt++;
      guard++;
    end
    chk("busy_cycles", busy_cnt, DEPTH);
  endtask

  initial begin
    logic [31:0] c1;
    logic [31:0] c2;
    int unsigned gap;

    reset = 1'b0; rw = 1'b1; address = '0; datai = '0;
    model_reset();
    do_reset(3);
    run_clear();

    cycle(32'(DEPTH - 1), 1'b1, '0);
    chk("ram_top_zero", obs_data, '0);

    cycle(32'd7, 1'b0, 32'hDEAD_BEEF);
    chk("same_cycle_old", obs_data, '0);
    cycle(32'd7, 1'b1, '0);
    chk("ram_rd7", obs_data, 32'hDEAD_BEEF);

    cycle(IO_BASE, 1'b0, 32'h0000_00A5);
    cycle(IO_BASE, 1'b1, '0);
    chk("out_pulse", {31'b0, io_valid}, 32'd1);
    chk("out_val", obs_data, 32'h0000_00A5);
    cycle(IO_BASE + 32'd1, 1'b1, '0);
    chk("out_pulse_end", {31'b0, io_valid}, '0);

    cycle(IO_BASE, 1'b0, 32'h11);
    cycle(IO_BASE, 1'b0, 32'h22);
    chk("pulse1", {31'b0, io_valid}, 32'd1);
    cycle(IO_BASE + 32'd2, 1'b1, '0);
    chk("pulse2", {31'b0, io_valid}, 32'd1);
    chk("pulse2_val", io_out, 32'h22);
    cycle(IO_BASE + 32'd2, 1'b1, '0);

    gap = 5 + $urandom_range(20);
    cycle(IO_BASE + 32'd1, 1'b1, '0);
    c1 = obs_data;
    repeat (gap - 1) cycle(32'd3, 1'b1, '0);
    cycle(IO_BASE + 32'd1, 1'b1, '0);
    c2 = obs_data;
    chk("cycle_delta", c2 - c1, gap);

    cycle(32'(DEPTH + 3), 1'b0, 32'd1);
    cycle(IO_BASE + 32'd9, 1'b0, 32'd1);
    cycle(IO_BASE + 32'd1, 1'b0, 32'hFFFF_0000);
    cycle(32'(DEPTH + 3), 1'b1, '0);
    chk("unmapped_rd", obs_data, '0);
    cycle(IO_BASE + 32'd9, 1'b1, '0);
    chk("io9_rd", obs_data, '0);
    cycle(32'd3, 1'b1, '0);
    chk("no_alias", obs_data, '0);

    for (int i = 0; i < 400; i++)
      cycle(rand_addr(), 1'($urandom_range(1)), $urandom);

`ifdef RESP_WRITE_PROTECT_EN
    cycle(32'd10, 1'b0, 32'h1234);
    cycle(32'd10, 1'b1, '0);
    chk("wp_drop", obs_data, '0);
    chk("wp_flag", {31'b0, wp_err}, 32'd1);
    cycle(IO_BASE + 32'd2, 1'b1, '0);
    chk("wp_status", obs_data, 32'd2);
    cycle(32'd64, 1'b0, 32'hCAFE_0064);
    cycle(32'd64, 1'b1, '0);
    chk("wp_edge_ok", obs_data, 32'hCAFE_0064);
`endif

    do_reset(1);
    repeat (50) cycle(rand_addr(), 1'($urandom_range(1)), $urandom);
    do_reset(2);
    run_clear();
    cycle(32'd7, 1'b1, '0);
    chk("swept_after_rst", obs_data, '0);
    cycle(IO_BASE + 32'd2, 1'b1, '0);
    chk("status_after_rst", obs_data, '0);
    for (int i = 0; i < 100; i++)
      cycle(rand_addr(), 1'($urandom_range(1)), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
